ines_loader: RTL and testbench
==============================

Name: ines_loader

Overview:
- Consumes the byte stream that the ROM feeder produces (one byte per strobe, framed by a downloading level) and parses the 16-byte iNES header.
- Writes PRG and CHR payload bytes into the cartridge memory through a request/acknowledge write port.
- Exports the decoded mapper and mirroring information to the mapper and PPU logic, plus done and error status.
- Sits directly downstream of the ROM byte feeder and upstream of the SDRAM/BRAM arbiter.

Parameters:
- ADDR_W, 22, memory byte-address width.
- CHR_BASE, 22'h200000, byte address where CHR data starts; PRG starts at 0.
- FIFO_DEPTH, 4, depth of the byte FIFO between parser and memory writer; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- indata  in  8  stream byte, valid when indata_clk=1
- indata_clk  in  1  one-cycle byte strobe
- downloading  in  1  high for the whole transfer; rising edge starts a load
- mem_addr  out  ADDR_W  write byte address
- mem_data  out  8  write data
- mem_write  out  1  write request, held until mem_ack
- mem_ack  in  1  one-cycle completion of the current write
- mapper  out  8  {byte7[7:4], byte6[7:4]}
- mirroring  out  2  {byte6[3] four-screen, byte6[0] vertical}
- prg_banks  out  8  header byte4 (16 KB units)
- chr_banks  out  8  header byte5 (8 KB units)
- done  out  1  load complete, sticky
- error  out  2  0 none, 1 bad magic/zero PRG, 2 stream ended early, 3 FIFO overflow; sticky

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE.
- States and transitions:
  - IDLE -> HEADER on a downloading rising edge. done and error clear on this edge.
  - HEADER: byte counter 0..15. Bytes 0-3 must equal 4E 45 53 1A; a mismatch goes to ERR (code 1) immediately. Bytes 4-7 are latched. Bytes 8-15 are discarded.
  - After byte 15:
    - prg_banks==0 -> ERR (code 1).
    - byte6[2]=1 -> TRAINER.
    - otherwise -> PRG.
  - TRAINER: discard 512 bytes -> PRG.
  - PRG: push prg_banks*16384 bytes to the FIFO, addresses 0 upward.
  - PRG complete:
    - chr_banks!=0 -> CHR.
    - chr_banks==0 -> DRAIN (or CLEAR when the optional feature is compiled in).
  - CHR: push chr_banks*8192 bytes, addresses CHR_BASE upward -> DRAIN.
  - DRAIN: once the FIFO is empty and no write is outstanding, done=1 -> DONE.
  - DONE / ERR: ignore strobes; leave only on a new downloading rising edge.
- Byte counter width 22 bits. Payload addresses come from a running counter, not a multiplication per byte. Sizes are computed once as prg_banks<<14 and chr_banks<<13.
- Stream bytes beyond the PRG+CHR payload are ignored (no error).
- downloading falls before the payload completes -> ERR (code 2). Writes already queued still drain.
- A strobe arriving while the FIFO is full -> byte dropped, ERR (code 3).
- Writer:
  - On FIFO not empty and mem_write=0: pops an entry and drives mem_addr, mem_data and mem_write=1 on the next cycle.
  - Holds those signals until mem_ack.
  - Pop and ack in the same cycle is allowed, giving back-to-back writes every 2 cycles minimum.
- mem_ack while mem_write=0 is ignored.
- Latency: strobe to mem_write assertion is 2 cycles when the FIFO is empty.
- Header outputs are valid from the cycle after byte 7 and hold until the next load.

Optional Feature:
- Macro: INES_LOADER_CHR_CLEAR_EN.
- Defined: when chr_banks==0, state CLEAR after PRG writes 8192 zero bytes to CHR_BASE..CHR_BASE+0x1FFF (CHR-RAM init) through the same FIFO/writer. done is raised after CLEAR drains.
- Undefined: the CLEAR state is absent; PRG complete with chr_banks==0 goes straight to DRAIN.

Decomposition:
- Shared package ines_pkg:
  - state enum
  - error code constants
  - magic bytes
  - PRG_UNIT=16384, CHR_UNIT=8192, TRAINER_LEN=512
- One natural sub-module: loader_byte_fifo, a parameterised synchronous FIFO with {addr,data} entries and full/empty flags.

Test Plan:
- Header 4E 45 53 1A 01 01 01 00 + 8 zeros, 16 KB PRG of i&FF, 8 KB CHR, mem_ack 1 cycle after each request:
  - 16384 writes at 0..0x3FFF
  - 8192 writes at 0x200000..0x201FFF
  - mapper=0, mirroring=01, then done=1, error=0
- Byte 3 = 0x1B: error=1 one cycle after that strobe, zero mem_write pulses, done=0.
- byte6=0x04 (trainer): the 512 bytes after the header are not written; the first PRG write at address 0 carries byte 528.
- mem_ack delayed 10 cycles per write, strobes every 4 cycles: error=3 once the FIFO is full, and the dropped byte is not written.
- downloading drops after 100 PRG bytes: error=2; the ≤100 queued writes complete; done stays 0.
- Reset asserted mid-PRG, then a new load: outputs return to 0 immediately, and the second load completes normally.
- With INES_LOADER_CHR_CLEAR_EN and chr_banks=0: 8192 zero writes at 0x200000.., then done=1.

Source files
------------

// File: rtl/ines_loader_pkg.sv
// ines_pkg: shared states, error codes and iNES header constants for the loader
package ines_pkg;
  typedef enum logic [3:0] {
    IDLE, HEADER, TRAINER, PRG, CHR,
`ifdef INES_LOADER_CHR_CLEAR_EN
    CLEAR,
`endif
    DRAIN, DONE, ERR
  } state_t;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_HDR = 2'd1, ERR_SHORT = 2'd2, ERR_OVF = 2'd3;
  localparam logic [31:0] MAGIC = 32'h4E45531A;
  localparam int PRG_UNIT = 16384, CHR_UNIT = 8192, TRAINER_LEN = 512;
  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    return MAGIC[{~i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ines_loader_byte_fifo.sv
// loader_byte_fifo: synchronous FIFO of {addr,data} write entries with full/empty flags
module loader_byte_fifo #(
  parameter int W = 30,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  // pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // storage needs no reset; only entries between rp and wp are ever read
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES stream and writes PRG/CHR to memory; INES_LOADER_CHR_CLEAR_EN adds CHR-RAM zero fill
module ines_loader import ines_pkg::*; #(
  parameter int ADDR_W = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE = 'h200000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        indata,
  input  logic              indata_clk,
  input  logic              downloading,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_write,
  input  logic              mem_ack,
  output logic [7:0]        mapper,
  output logic [1:0]        mirroring,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic              done,
  output logic [1:0]        error
);
`ifdef INES_LOADER_CHR_CLEAR_EN
  localparam state_t NO_CHR = CLEAR;
`else
  localparam state_t NO_CHR = DRAIN;
`endif
  state_t state;
  logic dl_q, trainer, rise, payload, push, pop, full, empty;
  logic [21:0] cnt, prg_size, chr_size;
  logic [ADDR_W-1:0] waddr;
  logic [7:0] pdata;
  logic [ADDR_W+7:0] fifo_out;
  assign rise = downloading && !dl_q;
  assign payload = state == PRG || state == CHR;
  assign prg_size = 22'(prg_banks) << $clog2(PRG_UNIT);
  assign chr_size = 22'(chr_banks) << $clog2(CHR_UNIT);
`ifdef INES_LOADER_CHR_CLEAR_EN
  assign push = !full && (state == CLEAR || (payload && indata_clk && downloading));
  assign pdata = state == CLEAR ? 8'h00 : indata;
`else
  assign push = !full && payload && indata_clk && downloading;
  assign pdata = indata;
`endif
  assign pop = !empty && (!mem_write || mem_ack);

  loader_byte_fifo #(.W(ADDR_W + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .wdata({waddr, pdata}),
    .pop(pop), .rdata(fifo_out), .full(full), .empty(empty)
  );

  // load sequencer: header parse, trainer skip, payload addressing, status
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      dl_q <= 1'b0;
      trainer <= 1'b0;
      cnt <= '0;
      waddr <= '0;
      mapper <= '0;
      mirroring <= '0;
      prg_banks <= '0;
      chr_banks <= '0;
      done <= 1'b0;
      error <= ERR_NONE;
    end else begin
      dl_q <= downloading;
      if (rise) begin
        state <= HEADER;
        cnt <= '0;
        waddr <= '0;
        trainer <= 1'b0;
        mapper <= '0;
        mirroring <= '0;
        prg_banks <= '0;
        chr_banks <= '0;
        done <= 1'b0;
        error <= ERR_NONE;
      end else if (!downloading && (state == HEADER || state == TRAINER || payload)) begin
        state <= ERR;
        error <= ERR_SHORT;
      end else begin
        case (state)
          HEADER: if (indata_clk) begin
            cnt <= cnt + 1'b1;
            if (cnt < 22'd4 && indata != magic_byte(cnt[1:0])) begin
              state <= ERR;
              error <= ERR_HDR;
            end
            if (cnt == 22'd4) prg_banks <= indata;
            if (cnt == 22'd5) chr_banks <= indata;
            if (cnt == 22'd6) begin
              mapper[3:0] <= indata[7:4];
              mirroring <= {indata[3], indata[0]};
              trainer <= indata[2];
            end
            if (cnt == 22'd7) mapper[7:4] <= indata[7:4];
            if (cnt == 22'd15) begin
              cnt <= '0;
              state <= prg_banks == 8'd0 ? ERR : trainer ? TRAINER : PRG;
              error <= prg_banks == 8'd0 ? ERR_HDR : ERR_NONE;
            end
          end
          TRAINER: if (indata_clk) begin
            cnt <= cnt == 22'(TRAINER_LEN - 1) ? '0 : cnt + 1'b1;
            if (cnt == 22'(TRAINER_LEN - 1)) state <= PRG;
          end
          PRG, CHR: if (indata_clk) begin
            if (full) begin
              state <= ERR;
              error <= ERR_OVF;
            end else begin
              waddr <= waddr + 1'b1;
              cnt <= cnt + 1'b1;
              if (cnt == (state == PRG ? prg_size : chr_size) - 1'b1) begin
                cnt <= '0;
                waddr <= CHR_BASE;
                state <= state == CHR ? DRAIN : chr_banks != 8'd0 ? CHR : NO_CHR;
              end
            end
          end
`ifdef INES_LOADER_CHR_CLEAR_EN
          CLEAR: if (!full) begin
            waddr <= waddr + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == 22'(CHR_UNIT - 1)) state <= DRAIN;
          end
`endif
          DRAIN: if (empty && !mem_write) begin
            done <= 1'b1;
            state <= DONE;
          end
          default: ;
        endcase
      end
    end

  // writer: present one FIFO entry and hold it until acknowledged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      {mem_addr, mem_data} <= fifo_out;
      mem_write <= 1'b1;
    end else if (mem_ack) begin
      mem_write <= 1'b0;
    end
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: directed loads checked against a payload-order write model
module tb_ines_loader;
`ifdef INES_LOADER_CHR_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, indata_clk, downloading, mem_ack, mem_write, done;
  logic [7:0] indata, mem_data, mapper, prg_banks, chr_banks;
  logic [21:0] mem_addr, first_addr;
  logic [1:0] mirroring, error;
  logic [7:0] first_data;
  int vectors = 0, miscompares = 0, widx = 0, wr_cycles = 0;
  int cfg_prg = 16384, cfg_chr = 8192, ack_delay = 1, wait_cnt = 0, k_drop = -1;
  bit cfg_clear = 1'b0;

  ines_loader dut (
    .clk(clk), .reset(reset), .indata(indata), .indata_clk(indata_clk),
    .downloading(downloading), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write(mem_write), .mem_ack(mem_ack), .mapper(mapper),
    .mirroring(mirroring), .prg_banks(prg_banks), .chr_banks(chr_banks),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // stream byte at payload index i: PRG byte i is i&FF, CHR byte j is (j&FF)^5A
  function automatic logic [7:0] pay_byte(input int i);
    int c = i - cfg_prg;
    return i < cfg_prg ? i[7:0] : c[7:0] ^ 8'h5A;
  endfunction

  // i-th memory write of a load: PRG from 0, then CHR (or zero fill) from 0x200000
  function automatic logic [29:0] exp_write(input int i);
    int c = i - cfg_prg;
    if (i < cfg_prg) return {i[21:0], pay_byte(i)};
    return {22'h200000 + c[21:0], cfg_clear ? 8'h00 : pay_byte(i)};
  endfunction

  // memory model: acknowledge each request ack_delay cycles after it is seen
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_write) wait_cnt = 0;
      else if (wait_cnt == ack_delay) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
      end else wait_cnt++;
    end
  end

  // every completed write must be the next one of the expected sequence
  always @(negedge clk) begin
    if (mem_write) wr_cycles++;
    if (mem_write && mem_ack) begin
      if (widx == 0) begin
        first_addr = mem_addr;
        first_data = mem_data;
      end
      chk($sformatf("write[%0d]", widx), {mem_addr, mem_data}, exp_write(widx));
      widx++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    indata = b;
    indata_clk = 1'b1;
    @(posedge clk); #1;
    indata_clk = 1'b0;
    repeat (gap - 2) begin @(posedge clk); #1; end
  endtask

  task automatic start_load();
    widx = 0;
    wr_cycles = 0;
    first_addr = '1;
    first_data = 8'hFF;
    @(posedge clk); #1;
    downloading = 1'b1;
  endtask

  task automatic send_header(input logic [7:0] m3, p, c, f6, f7);
    logic [7:0] h [16];
    h = '{8'h4E, 8'h45, 8'h53, m3, p, c, f6, f7, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    for (int i = 0; i < 16; i++) begin
      send(h[i], 2);
      if (i == 3) chk("magic_err", error, m3 == 8'h1A ? 32'd0 : 32'd1);
      if (i == 7 && m3 == 8'h1A) begin
        chk("hdr_prg", prg_banks, p);
        chk("hdr_chr", chr_banks, c);
        chk("hdr_mapper", mapper, {f7[7:4], f6[7:4]});
        chk("hdr_mirror", mirroring, {f6[3], f6[0]});
      end
    end
  endtask

  task automatic send_stream(input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) send(pay_byte(i), gap);
  endtask

  task automatic wait_done(input int limit);
    int t = 0;
    while (!done && t < limit) begin @(negedge clk); t++; end
    chk("done_in_time", done, 1);
  endtask

  task automatic wait_quiet();
    int q = 0, t = 0;
    while (q < 20 && t < 5000) begin
      @(negedge clk);
      q = mem_write ? 0 : q + 1;
      t++;
    end
    chk("drain_in_time", q >= 20, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    downloading = 1'b0;
    indata = 8'h00;
    indata_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mapper", mapper, 0);
    chk("rst_prg", prg_banks, 0);
    // reset in the middle of a PRG payload
    start_load();
    send_header(8'h1A, 8'h01, 8'h01, 8'h01, 8'h00);
    send_stream(0, 50, 2);
    chk("pre_rst_prg", prg_banks, 8'h01);
    reset = 1'b1;
    downloading = 1'b0;
    #2;
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_prg", prg_banks, 0);
    chk("mid_rst_chr", chr_banks, 0);
    chk("mid_rst_mirror", mirroring, 0);
    chk("mid_rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // full load: 16 KB PRG and 8 KB CHR (zero fill instead when compiled in)
    cfg_prg = 16384;
    cfg_chr = CLR ? 0 : 8192;
    cfg_clear = CLR;
    start_load();
    send_header(8'h1A, 8'h01, CLR ? 8'h00 : 8'h01, 8'h01, 8'h00);
    @(posedge clk); #1;
    indata = pay_byte(0);
    indata_clk = 1'b1;
    @(posedge clk); #1;
    indata_clk = 1'b0;
    chk("latency_1", mem_write, 0);
    @(posedge clk); #1;
    chk("latency_2", mem_write, 1);
    send_stream(1, cfg_prg + cfg_chr - 1, 2);
    send(8'hA5, 2);
    send(8'h5A, 2);
    wait_done(40000);
    chk("full_writes", widx, cfg_prg + (CLR ? 8192 : cfg_chr));
    chk("full_error", error, 0);
    chk("full_mapper", mapper, 8'h00);
    chk("full_mirror", mirroring, 2'b01);
    chk("full_first_addr", first_addr, 22'h0);
    chk("full_first_data", first_data, 8'h00);
    downloading = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("full_done_sticky", done, 1);
    // bad magic byte 3
    cfg_chr = 8192;
    cfg_clear = 1'b0;
    start_load();
    send_header(8'h1B, 8'h01, 8'h01, 8'h01, 8'h00);
    send_stream(0, 20, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_wr_cycles", wr_cycles, 0);
    chk("bad_done", done, 0);
    chk("bad_error", error, 1);
    downloading = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("bad_error_sticky", error, 1);
    // trainer skipped, then stream ends after 100 PRG bytes
    start_load();
    send_header(8'h1A, 8'h01, 8'h01, 8'h04, 8'h40);
    for (int i = 0; i < 512; i++) send(8'hEE, 2);
    send_stream(0, 100, 2);
    downloading = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("short_error", error, 2);
    wait_quiet();
    chk("short_writes", widx, 100);
    chk("short_done", done, 0);
    chk("trn_first_addr", first_addr, 22'h0);
    chk("trn_first_data", first_data, 8'h00);
    chk("trn_mapper", mapper, 8'h40);
    chk("trn_mirror", mirroring, 2'b00);
    // slow memory overruns the FIFO
    cfg_chr = 0;
    ack_delay = 10;
    start_load();
    send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
    k_drop = -1;
    for (int i = 0; i < 64 && k_drop < 0; i++) begin
      send(pay_byte(i), 4);
      if (error == 2'd3) k_drop = i;
    end
    chk("ovf_seen", k_drop >= 0, 1);
    chk("ovf_after_depth", k_drop > 4, 1);
    wait_quiet();
    chk("ovf_writes", widx, k_drop);
    chk("ovf_error", error, 3);
    chk("ovf_done", done, 0);
    downloading = 1'b0;
    ack_delay = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
